// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared loot types, loot table constants and reel FSM states
//
// Purpose: types and constants shared by the loot reel controller and its
//          loot table.
// Contents: loot_e (loot type), reel_state_e (reel FSM state),
//           BASE_SPEED_DEFAULT, per-type speed/value constants, is_loot().
package game_pkg;

  typedef enum logic [2:0] {
    LOOT_EMPTY      = 3'd0,
    LOOT_GOLD_SMALL = 3'd1,
    LOOT_GOLD_BIG   = 3'd2,
    LOOT_ROCK       = 3'd3,
    LOOT_DIAMOND    = 3'd4,
    LOOT_BAG        = 3'd5
  } loot_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ATTACHED = 2'd1,
    ST_PAYOUT   = 2'd2
  } reel_state_e;

  localparam int BASE_SPEED_DEFAULT = 4;

  localparam logic [3:0]  SPEED_GOLD_SMALL = 4'd4;
  localparam logic [3:0]  SPEED_GOLD_BIG   = 4'd1;
  localparam logic [3:0]  SPEED_ROCK       = 4'd2;
  localparam logic [3:0]  SPEED_DIAMOND    = 4'd8;
  localparam logic [3:0]  SPEED_BAG        = 4'd4;

  localparam logic [11:0] VALUE_GOLD_SMALL = 12'd50;
  localparam logic [11:0] VALUE_GOLD_BIG   = 12'd500;
  localparam logic [11:0] VALUE_ROCK       = 12'd20;
  localparam logic [11:0] VALUE_DIAMOND    = 12'd600;
  localparam logic [11:0] VALUE_BAG        = 12'd100;

  // Types 6 and 7 are unused codes and behave like EMPTY.
  function automatic logic is_loot(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd5);
  endfunction

endpackage

// File: rtl/loot_table.sv
// rtl/loot_table.sv - combinational loot type to speed/value lookup
//
// Purpose: maps a loot type to the claw speed while reeling it and its
//          score value. EMPTY and unused codes give BASE_SPEED and 0.
// Ports:
//   loot_type_i [2:0]  - loot type to look up
//   speed_o     [3:0]  - claw speed with this loot attached
//   value_o     [11:0] - points awarded on delivery
module loot_table
  import game_pkg::*;
#(
  parameter int BASE_SPEED = BASE_SPEED_DEFAULT
) (
  input  logic [2:0]  loot_type_i,
  output logic [3:0]  speed_o,
  output logic [11:0] value_o
);

  always_comb begin
    speed_o = 4'(BASE_SPEED);
    value_o = 12'd0;
    case (loot_type_i)
      LOOT_GOLD_SMALL: begin speed_o = SPEED_GOLD_SMALL; value_o = VALUE_GOLD_SMALL; end
      LOOT_GOLD_BIG:   begin speed_o = SPEED_GOLD_BIG;   value_o = VALUE_GOLD_BIG;   end
      LOOT_ROCK:       begin speed_o = SPEED_ROCK;       value_o = VALUE_ROCK;       end
      LOOT_DIAMOND:    begin speed_o = SPEED_DIAMOND;    value_o = VALUE_DIAMOND;    end
      LOOT_BAG:        begin speed_o = SPEED_BAG;        value_o = VALUE_BAG;        end
      default: ;
    endcase
  end

endmodule

// File: rtl/loot_reel_ctrl.sv
// rtl/loot_reel_ctrl.sv - claw loot capture, reel-in speed and payout control
//
// Purpose: latches the first real loot the claw touches, slows the claw to
//          that loot's speed, drags the loot with the claw, and on return
//          emits a one-cycle score/consume pulse and counts the delivery.
// Ports:
//   clk, resetN (async, active-low)
//   start_level                         - sync level restart, highest priority
//   claw_collision, loot_type[2:0]      - claw touched an object of this type
//   claw_returned                       - claw back at pivot
//   claw_topLeftX/Y[10:0] signed        - claw position
//   move_speed[3:0]                     - registered claw speed
//   loot_attached                       - loot is being reeled
//   loot_topLeftX/Y[10:0] signed        - registered loot draw position
//   score_valid, score_add[11:0]        - payout pulse and points
//   loot_consumed                       - remove object from field (pulse)
//   loot_count[5:0]                     - deliveries this level, saturating
module loot_reel_ctrl
  import game_pkg::*;
#(
  parameter int BASE_SPEED = BASE_SPEED_DEFAULT,
  parameter int OFFSET_X   = 0,
  parameter int OFFSET_Y   = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_level,
  input  logic               claw_collision,
  input  logic [2:0]         loot_type,
  input  logic               claw_returned,
  input  logic signed [10:0] claw_topLeftX,
  input  logic signed [10:0] claw_topLeftY,
  output logic [3:0]         move_speed,
  output logic               loot_attached,
  output logic signed [10:0] loot_topLeftX,
  output logic signed [10:0] loot_topLeftY,
  output logic               score_valid,
  output logic [11:0]        score_add,
  output logic               loot_consumed,
  output logic [5:0]         loot_count
);

  localparam logic signed [10:0] OFF_X = 11'(OFFSET_X);
  localparam logic signed [10:0] OFF_Y = 11'(OFFSET_Y);

  reel_state_e        state_q, state_d;
  logic [2:0]         type_q;
  logic [3:0]         speed_q;
  logic signed [10:0] loot_x_q, loot_y_q;
  logic [5:0]         count_q;
  logic [3:0]         tbl_speed;
  logic [11:0]        tbl_value;
  logic [2:0]         tbl_type;

  // One table serves both lookups: the incoming type while idle (speed for
  // the capture edge) and the latched type otherwise (value for payout).
  assign tbl_type = (state_q == ST_IDLE) ? loot_type : type_q;

  loot_table #(.BASE_SPEED(BASE_SPEED)) u_table (
    .loot_type_i (tbl_type),
    .speed_o     (tbl_speed),
    .value_o     (tbl_value)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_level) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        // claw_returned is meaningless while idle, so a coincident capture wins
        ST_IDLE:     if (claw_collision && is_loot(loot_type)) state_d = ST_ATTACHED;
        ST_ATTACHED: if (claw_returned) state_d = ST_PAYOUT;
        ST_PAYOUT:   state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    loot_attached = (state_q == ST_ATTACHED);
    score_valid   = (state_q == ST_PAYOUT);
    loot_consumed = (state_q == ST_PAYOUT);
    score_add     = (state_q == ST_PAYOUT) ? tbl_value : 12'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      type_q   <= LOOT_EMPTY;
      speed_q  <= 4'(BASE_SPEED);
      loot_x_q <= '0;
      loot_y_q <= '0;
      count_q  <= '0;
    end else begin
      if (state_d == ST_IDLE) begin
        type_q  <= LOOT_EMPTY;
        speed_q <= 4'(BASE_SPEED);
      end else if (state_q == ST_IDLE) begin
        type_q  <= loot_type;
        speed_q <= tbl_speed;
      end
      if (state_d == ST_ATTACHED) begin
        loot_x_q <= claw_topLeftX + OFF_X;
        loot_y_q <= claw_topLeftY + OFF_Y;
      end
      if (start_level)
        count_q <= '0;
      else if (state_q == ST_PAYOUT && count_q != 6'd63)
        count_q <= count_q + 6'd1;
    end
  end

  assign move_speed    = speed_q;
  assign loot_topLeftX = loot_x_q;
  assign loot_topLeftY = loot_y_q;
  assign loot_count    = count_q;

endmodule
